i2c_target_regs: RTL and testbench
==================================

Name: i2c_target_regs

Overview:
- I2C target (slave) responder: the other end of the team's I2C master driver.
- Lets an external I2C master, such as the flight computer or a bench rig, read and write an 8-bit-addressed register space.
- The host side is typically a mux over the sensor registers or the drop-command bits.
- Sits beside the sensor controllers on the top level, driving one open-drain SDA pin and sampling SCL.

Parameters:
DEV_ADDR, 7'h42, 7-bit target address this block answers to.
SYNC_STAGES, 2, flip-flop synchroniser depth on SCL/SDA (min 2).

Ports:
clk  in  1  system clock (>= 20x SCL frequency; 50 MHz nominal).
rst_n  in  1  asynchronous, active-low reset.
scl  in  1  I2C clock from master (never driven; no clock stretching).
sda  inout  1  I2C data; driven only to 0 or z.
reg_addr  out  8  current register pointer.
reg_rd_data  in  8  host data for reg_addr; combinational or valid 1 clk after reg_addr changes.
reg_rd  out  1  one-clk pulse when reg_rd_data is latched for transmit.
reg_wr  out  1  one-clk pulse; reg_addr/reg_wr_data valid the same cycle.
reg_wr_data  out  8  received write byte.
busy  out  1  high from an address-matched START until STOP.

Behaviour:
Reset:
- sda=z, reg_addr=0, reg_wr_data=0, reg_rd=0, reg_wr=0, busy=0, state=IDLE.
- Asserting rst_n low mid-transfer releases sda immediately, not at a clock edge.

Line conditioning:
- scl/sda pass through SYNC_STAGES flops plus one history flop; edges are detected on synced values.
- START = synced SDA fall while SCL high; STOP = synced SDA rise while SCL high.
- START or STOP in any state has priority over bit handling. START -> ADDR (repeated START allowed); STOP -> IDLE with busy=0.

Timing:
- Input bits are sampled on synced SCL rise.
- sda output changes only on synced SCL fall.

States:
- IDLE: wait for START.
- ADDR: shift 8 bits MSB first. On the 8th bit: if [7:1]==DEV_ADDR, go to ACK_A; else go to IGNORE (sda=z until START/STOP).
- ACK_A: drive sda=0 from the SCL fall after bit 8 to the SCL fall after bit 9.
  - If R/W=0 -> PTR.
  - If R/W=1 -> latch reg_rd_data at that first fall, pulse reg_rd, then -> RDATA.
- PTR: receive 8 bits -> reg_addr; ACK -> WDATA.
- WDATA: receive 8 bits; at the ACK-slot fall, pulse reg_wr with the byte; ACK. reg_addr increments the cycle after reg_wr.
- RDATA: drive shift-register bits MSB first (drive 0 for a 0 bit, z for a 1 bit); after bit 8 release sda -> MACK.
- MACK: sample master bit on SCL rise.
  - 0 (ACK): reg_addr++, latch the new reg_rd_data at next fall (2 clk after pointer change), pulse reg_rd, -> RDATA.
  - 1 (NACK): reg_addr++ (byte consumed), -> WAIT (sda=z until START/STOP).

Pointer:
- 8-bit, wraps 0xFF->0x00 silently.
- Persists across transactions; only reset clears it.

Other rules:
- A write with only the address byte then STOP leaves reg_addr unchanged.
- All write bytes are ACKed; there is no NACK-on-full.
- A general call (address 0) is ignored.

Decomposition:
- Shared package holds the state enum (IDLE, ADDR, ACK_A, PTR, WDATA, ACK_W, RDATA, MACK, WAIT, IGNORE) and I2C_RW_READ=1.
- One sub-module, i2c_line_cond: synchroniser plus edge/START/STOP detect, outputting scl_rise, scl_fall, start, stop and sda_s.
- The FSM and shift logic stay in the top.

Test Plan:
- Write 0x84 (addr 0x42,W), 0x10, 0xAB, 0xCD, STOP -> ACK on all 4 bytes.
  - reg_wr pulses twice: (0x10, 0xAB) then (0x11, 0xCD).
  - Final reg_addr=0x12; busy falls at STOP.
- Write pointer 0x20, repeated START, 0x85, read 3 bytes ACK,ACK,NACK (host returns addr^0xFF) -> master sees 0xDF, 0xDE, 0xDD.
  - reg_rd pulses 3 times; reg_addr=0x23 after NACK.
- Address 0x86 (wrong target) plus 2 data bytes -> sda never driven low, no reg_wr/reg_rd, busy stays 0.
- Write pointer 0xFF, data 0x11, 0x22 -> writes land at 0xFF then 0x00; reg_addr=0x01.
- Deassert-assert rst_n during the 4th bit of a read byte with data 0x00 -> sda goes z within the reset assertion, outputs return to reset values.
  - Next transaction (write ptr 0x05) ACKs normally.
- STOP issued mid-data-byte after 4 bits -> no reg_wr, state IDLE, reg_addr unchanged.

Source files
------------

// File: rtl/i2c_target_regs_pkg.sv
// i2c_target_regs_pkg: shared state encoding and protocol constants for the I2C target
package i2c_target_regs_pkg;
  typedef enum logic [3:0] {
    IDLE, ADDR, ACK_A, PTR, WDATA, ACK_W, RDATA, MACK, WAIT, IGNORE
  } state_t;
  localparam logic I2C_RW_READ = 1'b1;
endpackage

// File: rtl/i2c_line_cond.sv
// i2c_line_cond: synchronises SCL/SDA and detects SCL edges plus START/STOP
//   clk, rst_n      : system clock, async active-low reset
//   scl, sda        : raw bus lines
//   scl_rise/fall   : one-clk pulses on synced SCL edges
//   start/stop      : one-clk pulses on synced SDA fall/rise while SCL high
//   sda_s           : synced SDA level
module i2c_line_cond #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic scl,
  input  logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop,
  output logic sda_s
);
  logic [SYNC_STAGES-1:0] scl_q, sda_q;
  logic scl_s, scl_d, sda_d;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      scl_q <= '1;
      sda_q <= '1;
      scl_d <= 1'b1;
      sda_d <= 1'b1;
    end else begin
      scl_q <= {scl_q[SYNC_STAGES-2:0], scl};
      sda_q <= {sda_q[SYNC_STAGES-2:0], sda};
      scl_d <= scl_s;
      sda_d <= sda_s;
    end
  assign scl_s    = scl_q[SYNC_STAGES-1];
  assign sda_s    = sda_q[SYNC_STAGES-1];
  assign scl_rise = scl_s & ~scl_d;
  assign scl_fall = ~scl_s & scl_d;
  assign start    = scl_s & scl_d & sda_d & ~sda_s;
  assign stop     = scl_s & scl_d & ~sda_d & sda_s;
endmodule

// File: rtl/i2c_target_regs.sv
// i2c_target_regs: I2C target exposing an 8-bit-addressed register space to a host mux
//   clk, rst_n      : system clock (>= 20x SCL), async active-low reset
//   scl, sda        : I2C bus; sda is only ever pulled low or released
//   reg_addr        : register pointer, auto-increments after each byte
//   reg_rd_data     : host data for reg_addr
//   reg_rd / reg_wr : one-clk strobes for a latched read / a received write byte
//   reg_wr_data     : received write byte
//   busy            : addressed transaction in progress
module i2c_target_regs
  import i2c_target_regs_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR    = 7'h42,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl,
  inout  wire        sda,
  output logic [7:0] reg_addr,
  input  logic [7:0] reg_rd_data,
  output logic       reg_rd,
  output logic       reg_wr,
  output logic [7:0] reg_wr_data,
  output logic       busy
);
  state_t state, state_n;
  logic [3:0] cnt, cnt_n;
  logic [7:0] sr, sr_n, addr_n, wdata_n, byte_in;
  logic drv, drv_n, pend, pend_n, wr_n, rd_n, busy_n;
  logic scl_rise, scl_fall, start, stop, sda_s, rx, last, match;
  i2c_line_cond #(.SYNC_STAGES(SYNC_STAGES)) u_line (
    .clk(clk), .rst_n(rst_n), .scl(scl), .sda(sda),
    .scl_rise(scl_rise), .scl_fall(scl_fall), .start(start), .stop(stop), .sda_s(sda_s)
  );
  // drv is cleared by the async reset, so the pin is released without waiting for a clock
  assign sda     = drv ? 1'b0 : 1'bz;
  assign byte_in = {sr[6:0], sda_s};
  assign rx      = state == ADDR || state == PTR || state == WDATA;
  assign last    = rx && scl_rise && cnt == 4'd7;
  assign match   = byte_in[7:1] == DEV_ADDR && byte_in[7:1] != 7'd0;
  // pend: in ACK_A it flags a read, in ACK_W a pending data byte, in MACK a master ACK
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    sr_n    = sr;
    drv_n   = drv;
    pend_n  = pend;
    addr_n  = reg_wr ? reg_addr + 8'd1 : reg_addr;
    wdata_n = reg_wr_data;
    busy_n  = busy;
    wr_n    = 1'b0;
    rd_n    = 1'b0;
    if (start) begin
      state_n = ADDR;
      cnt_n   = 4'd0;
      drv_n   = 1'b0;
      pend_n  = 1'b0;
    end else if (stop) begin
      state_n = IDLE;
      drv_n   = 1'b0;
      busy_n  = 1'b0;
    end else begin
      if (rx && scl_rise) begin
        sr_n  = byte_in;
        cnt_n = cnt + 4'd1;
      end
      case (state)
        ADDR: if (last) begin
          state_n = match ? ACK_A : IGNORE;
          busy_n  = match;
        end
        ACK_A: if (scl_fall) begin
          if (!drv) begin
            drv_n  = 1'b1;
            pend_n = sr[0] == I2C_RW_READ;
            rd_n   = sr[0] == I2C_RW_READ;
            sr_n   = sr[0] == I2C_RW_READ ? reg_rd_data : sr;
          end else begin
            state_n = pend ? RDATA : PTR;
            drv_n   = pend & ~sr[7];
            cnt_n   = pend ? 4'd1 : 4'd0;
            pend_n  = 1'b0;
          end
        end
        PTR: if (last) begin
          addr_n  = byte_in;
          state_n = ACK_W;
        end
        WDATA: if (last) begin
          pend_n  = 1'b1;
          state_n = ACK_W;
        end
        ACK_W: if (scl_fall) begin
          if (!drv) begin
            drv_n   = 1'b1;
            wr_n    = pend;
            wdata_n = pend ? sr : reg_wr_data;
            pend_n  = 1'b0;
          end else begin
            drv_n   = 1'b0;
            state_n = WDATA;
            cnt_n   = 4'd0;
          end
        end
        RDATA: if (scl_fall) begin
          if (cnt == 4'd8) begin
            drv_n   = 1'b0;
            state_n = MACK;
          end else begin
            sr_n  = {sr[6:0], 1'b0};
            drv_n = ~sr[6];
            cnt_n = cnt + 4'd1;
          end
        end
        MACK:
          if (scl_rise && !pend) begin
            addr_n  = reg_addr + 8'd1;
            pend_n  = ~sda_s;
            state_n = sda_s ? WAIT : MACK;
          end else if (scl_fall && pend) begin
            sr_n    = reg_rd_data;
            rd_n    = 1'b1;
            drv_n   = ~reg_rd_data[7];
            cnt_n   = 4'd1;
            pend_n  = 1'b0;
            state_n = RDATA;
          end
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      sr          <= 8'd0;
      drv         <= 1'b0;
      pend        <= 1'b0;
      reg_addr    <= 8'd0;
      reg_wr_data <= 8'd0;
      reg_wr      <= 1'b0;
      reg_rd      <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      sr          <= sr_n;
      drv         <= drv_n;
      pend        <= pend_n;
      reg_addr    <= addr_n;
      reg_wr_data <= wdata_n;
      reg_wr      <= wr_n;
      reg_rd      <= rd_n;
      busy        <= busy_n;
    end
endmodule

// File: tb/tb_i2c_target_regs.sv
// tb_i2c_target_regs: directed I2C master transactions against i2c_target_regs
module tb_i2c_target_regs;
  import i2c_target_regs_pkg::*;
  localparam int Q = 10;
  logic clk = 1'b0, rst_n = 1'b0, scl = 1'b1, m_low = 1'b0;
  wire sda;
  logic [7:0] reg_addr, reg_rd_data, reg_wr_data;
  logic reg_rd, reg_wr, busy;
  int n_tests = 0, n_fail = 0, wr_cnt = 0, rd_cnt = 0;
  logic [15:0] wr_log[$];
  logic dut_low = 1'b0, busy_seen = 1'b0;
  pullup (sda);
  assign sda = m_low ? 1'b0 : 1'bz;
  assign reg_rd_data = reg_addr ^ 8'hFF;
  always #10 clk = ~clk;
  i2c_target_regs dut (
    .clk(clk), .rst_n(rst_n), .scl(scl), .sda(sda),
    .reg_addr(reg_addr), .reg_rd_data(reg_rd_data), .reg_rd(reg_rd),
    .reg_wr(reg_wr), .reg_wr_data(reg_wr_data), .busy(busy)
  );
  always @(negedge clk) begin
    if (reg_wr) begin
      wr_cnt++;
      wr_log.push_back({reg_addr, reg_wr_data});
    end
    if (reg_rd) rd_cnt++;
    if (sda === 1'b0 && !m_low) dut_low = 1'b1;
    if (busy) busy_seen = 1'b1;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic qwait();
    repeat (Q) @(negedge clk);
  endtask
  task automatic i2c_start();
    m_low = 1'b0; qwait();
    scl = 1'b1;   qwait();
    m_low = 1'b1; qwait();
    scl = 1'b0;   qwait();
  endtask
  task automatic i2c_stop();
    m_low = 1'b1; qwait();
    scl = 1'b1;   qwait();
    m_low = 1'b0; qwait();
  endtask
  task automatic send_bit(input logic b);
    m_low = ~b; qwait();
    scl = 1'b1; qwait(); qwait();
    scl = 1'b0; qwait();
  endtask
  task automatic read_bit(output logic b);
    m_low = 1'b0; qwait();
    scl = 1'b1;   qwait();
    b = sda;      qwait();
    scl = 1'b0;   qwait();
  endtask
  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    read_bit(b);
    ack = ~b;
  endtask
  task automatic read_byte(output logic [7:0] d, input logic ack);
    for (int i = 7; i >= 0; i--) read_bit(d[i]);
    send_bit(~ack);
  endtask
  initial begin
    logic ack, b;
    logic [7:0] d;
    int w0, r0;
    repeat (3) @(negedge clk);
    check("rst sda", sda, 1);
    check("rst addr", reg_addr, 8'h00);
    check("rst wdata", reg_wr_data, 8'h00);
    check("rst wr", reg_wr, 0);
    check("rst rd", reg_rd, 0);
    check("rst busy", busy, 0);
    rst_n = 1'b1;
    qwait();
    // plain write burst
    i2c_start();
    write_byte(8'h84, ack); check("t1 ack addr", ack, 1);
    write_byte(8'h10, ack); check("t1 ack ptr", ack, 1);
    write_byte(8'hAB, ack); check("t1 ack d0", ack, 1);
    write_byte(8'hCD, ack); check("t1 ack d1", ack, 1);
    check("t1 busy", busy, 1);
    i2c_stop();
    check("t1 busy stop", busy, 0);
    check("t1 wr count", wr_cnt, 2);
    check("t1 wr0", wr_log.size() > 0 ? wr_log[0] : 16'hxxxx, 16'h10AB);
    check("t1 wr1", wr_log.size() > 1 ? wr_log[1] : 16'hxxxx, 16'h11CD);
    check("t1 addr", reg_addr, 8'h12);
    // pointer set, repeated start, 3-byte read
    r0 = rd_cnt;
    i2c_start();
    write_byte(8'h84, ack); check("t2 ack addr", ack, 1);
    write_byte(8'h20, ack); check("t2 ack ptr", ack, 1);
    i2c_start();
    write_byte(8'h85, ack); check("t2 ack raddr", ack, 1);
    read_byte(d, 1'b1); check("t2 rd0", d, 8'hDF);
    read_byte(d, 1'b1); check("t2 rd1", d, 8'hDE);
    read_byte(d, 1'b0); check("t2 rd2", d, 8'hDD);
    i2c_stop();
    check("t2 rd count", rd_cnt - r0, 3);
    check("t2 addr", reg_addr, 8'h23);
    // wrong target address
    w0 = wr_cnt; r0 = rd_cnt; dut_low = 1'b0; busy_seen = 1'b0;
    i2c_start();
    write_byte(8'h86, ack); check("t3 nack addr", ack, 0);
    write_byte(8'h55, ack); check("t3 nack d0", ack, 0);
    write_byte(8'h00, ack); check("t3 nack d1", ack, 0);
    i2c_stop();
    check("t3 sda never low", dut_low, 0);
    check("t3 no wr", wr_cnt - w0, 0);
    check("t3 no rd", rd_cnt - r0, 0);
    check("t3 busy", busy_seen, 0);
    check("t3 addr", reg_addr, 8'h23);
    // pointer wrap
    wr_log.delete();
    i2c_start();
    write_byte(8'h84, ack);
    write_byte(8'hFF, ack);
    write_byte(8'h11, ack); check("t4 ack d0", ack, 1);
    write_byte(8'h22, ack); check("t4 ack d1", ack, 1);
    i2c_stop();
    check("t4 wr0", wr_log.size() > 0 ? wr_log[0] : 16'hxxxx, 16'hFF11);
    check("t4 wr1", wr_log.size() > 1 ? wr_log[1] : 16'hxxxx, 16'h0022);
    check("t4 addr", reg_addr, 8'h01);
    // reset in the middle of a read byte that is all zeros
    i2c_start();
    write_byte(8'h84, ack);
    write_byte(8'hFF, ack);
    i2c_start();
    write_byte(8'h85, ack); check("t5 ack raddr", ack, 1);
    for (int i = 0; i < 3; i++) begin
      read_bit(b);
      check("t5 bit", b, 0);
    end
    m_low = 1'b0;
    repeat (5) @(negedge clk);
    check("t5 driving", sda, 0);
    #3 rst_n = 1'b0;
    #2;
    check("t5 sda released", sda, 1);
    check("t5 addr", reg_addr, 8'h00);
    check("t5 busy", busy, 0);
    scl = 1'b1;
    qwait();
    rst_n = 1'b1;
    qwait();
    i2c_start();
    write_byte(8'h84, ack); check("t5 post ack addr", ack, 1);
    write_byte(8'h05, ack); check("t5 post ack ptr", ack, 1);
    i2c_stop();
    check("t5 post addr", reg_addr, 8'h05);
    // address-only write leaves the pointer alone
    i2c_start();
    write_byte(8'h84, ack);
    i2c_stop();
    check("t6 addr only", reg_addr, 8'h05);
    // STOP part-way through a data byte
    w0 = wr_cnt;
    i2c_start();
    write_byte(8'h84, ack);
    write_byte(8'h30, ack); check("t6 ack ptr", ack, 1);
    for (int i = 0; i < 4; i++) send_bit(i[0]);
    i2c_stop();
    check("t6 no wr", wr_cnt - w0, 0);
    check("t6 state", dut.state, IDLE);
    check("t6 addr", reg_addr, 8'h30);
    check("t6 busy", busy, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
